// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_pkg
// Purpose  : Shared constants for the AXI4-Lite master: controller state
//            encoding and AXI response codes.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

  // Controller state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RADDR = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_WRESP = 3'd4;

  // AXI RRESP / BRESP codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage : axi4_lite_pkg
`default_nettype wire

// File: rtl/axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_master
// Purpose  : Single-outstanding AXI4-Lite master. Accepts one user command
//            at a time, runs the matching read or write transaction and
//            returns the response as a one-cycle completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  // user command / response
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  // read address channel
  output logic [ADDRESS_WIDTH-1:0]  M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  // read data channel
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY,
  // write address channel
  output logic [ADDRESS_WIDTH-1:0]  M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  // write data channel
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [2:0]               state_q,     state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q,     wdata_d;
  logic [STRB_WIDTH-1:0]    wstrb_q,     wstrb_d;
  logic                     arvalid_q,   arvalid_d;
  logic                     rready_q,    rready_d;
  logic                     awvalid_q,   awvalid_d;
  logic                     wvalid_q,    wvalid_d;
  logic                     bready_q,    bready_d;
  logic                     aw_done_q,   aw_done_d;
  logic                     w_done_q,    w_done_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]               rsp_resp_q,  rsp_resp_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  // Handshakes are qualified by our own registered VALID/READY flags
  assign ar_hs = arvalid_q & M_AXI_ARREADY;
  assign r_hs  = rready_q  & M_AXI_RVALID;
  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q  & M_AXI_WREADY;
  assign b_hs  = bready_q  & M_AXI_BVALID;

  assign cmd_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

  // Next-state logic: every channel flag is computed here and registered
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = ST_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_RADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          state_d     = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // AW and W complete independently, in either order or together
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight transaction silently
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

endmodule : axi4_lite_master
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_master
// Purpose  : Self-checking bench for axi4_lite_master with a behavioural
//            AXI4-Lite slave (programmable ready delays and responses) and
//            a word-array reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_ARADDR, M_AXI_RDATA, M_AXI_AWADDR, M_AXI_WDATA;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [1:0]  M_AXI_RRESP, M_AXI_BRESP;
  logic [3:0]  M_AXI_WSTRB;

  always #5 ACLK = ~ACLK;

  axi4_lite_master #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
  );

  // ---------------- behavioural slave ----------------
  int         ar_delay = 0, aw_delay = 0, w_delay = 0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  logic       b_hold = 1'b0;
  int         ar_wait, aw_wait, w_wait;
  logic [31:0] slv_mem [16];
  logic        got_aw, got_w;
  logic [31:0] aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  logic        s_aw_hs, s_w_hs, commit;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  assign M_AXI_ARREADY = (ar_wait >= ar_delay);
  assign M_AXI_AWREADY = (aw_wait >= aw_delay);
  assign M_AXI_WREADY  = (w_wait  >= w_delay);
  assign s_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign s_w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign commit  = ARESETN && (s_aw_hs || s_w_hs) && (got_aw || s_aw_hs) && (got_w || s_w_hs);
  assign wr_addr = got_aw ? aw_addr_s : M_AXI_AWADDR;
  assign wr_data = got_w  ? w_data_s  : M_AXI_WDATA;
  assign wr_strb = got_w  ? w_strb_s  : M_AXI_WSTRB;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_wait <= 0; aw_wait <= 0; w_wait <= 0;
      got_aw <= 1'b0; got_w <= 1'b0;
      M_AXI_RVALID <= 1'b0; M_AXI_BVALID <= 1'b0;
      M_AXI_RDATA <= '0; M_AXI_RRESP <= '0; M_AXI_BRESP <= '0;
      aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
    end else begin
      if (M_AXI_ARVALID && M_AXI_ARREADY) ar_wait <= 0; else if (M_AXI_ARVALID) ar_wait <= ar_wait + 1;
      if (s_aw_hs) aw_wait <= 0; else if (M_AXI_AWVALID) aw_wait <= aw_wait + 1;
      if (s_w_hs) w_wait <= 0; else if (M_AXI_WVALID) w_wait <= w_wait + 1;
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= slv_mem[M_AXI_ARADDR[5:2]];
        M_AXI_RRESP  <= rresp_cfg;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if (commit) begin
        got_aw <= 1'b0; got_w <= 1'b0;
        M_AXI_BVALID <= !b_hold;
        M_AXI_BRESP  <= bresp_cfg;
      end else begin
        if (s_aw_hs) begin got_aw <= 1'b1; aw_addr_s <= M_AXI_AWADDR; end
        if (s_w_hs) begin got_w <= 1'b1; w_data_s <= M_AXI_WDATA; w_strb_s <= M_AXI_WSTRB; end
      end
    end
  end

  always @(posedge ACLK) begin
    if (commit)
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) slv_mem[wr_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
  end

  // ---------------- cycle counter and channel monitors ----------------
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int ar_hs_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
  logic [31:0] ar_addr_seen = '0;
  int arv_cnt = 0, ar_stall_cnt = 0, awv_cnt = 0, wv_cnt = 0, b_hs_cnt = 0, rsp_cnt = 0, stab_err = 0;
  logic p_rstn = 1'b0, p_arv = 1'b0, p_arr = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
  logic [31:0] p_ara = '0, p_awa = '0, p_wd = '0;
  logic [3:0]  p_ws = '0;

  always @(negedge ACLK) begin
    if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_hs_cyc <= cyc; ar_addr_seen <= M_AXI_ARADDR; end
    if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs_cyc <= cyc;
    if (M_AXI_WVALID && M_AXI_WREADY) w_hs_cyc <= cyc;
    if (M_AXI_ARVALID) arv_cnt <= arv_cnt + 1;
    if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_stall_cnt <= ar_stall_cnt + 1;
    if (M_AXI_AWVALID) awv_cnt <= awv_cnt + 1;
    if (M_AXI_WVALID) wv_cnt <= wv_cnt + 1;
    if (M_AXI_BVALID && M_AXI_BREADY) b_hs_cnt <= b_hs_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (ARESETN && p_rstn &&
        ((p_arv && !p_arr && (!M_AXI_ARVALID || M_AXI_ARADDR != p_ara)) ||
         (p_awv && !p_awr && (!M_AXI_AWVALID || M_AXI_AWADDR != p_awa)) ||
         (p_wv && !p_wr && (!M_AXI_WVALID || M_AXI_WDATA != p_wd || M_AXI_WSTRB != p_ws))))
      stab_err <= stab_err + 1;
    p_rstn <= ARESETN;
    p_arv <= M_AXI_ARVALID; p_arr <= M_AXI_ARREADY; p_ara <= M_AXI_ARADDR;
    p_awv <= M_AXI_AWVALID; p_awr <= M_AXI_AWREADY; p_awa <= M_AXI_AWADDR;
    p_wv <= M_AXI_WVALID; p_wr <= M_AXI_WREADY; p_wd <= M_AXI_WDATA; p_ws <= M_AXI_WSTRB;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // Issue one command (caller is at negedge+1 with the master idle) and
  // return at the negedge+1 where rsp_valid is seen.
  task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output int t0,
                        output int busy_rdy, output logic ok);
    ok = 1'b0; busy_rdy = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    t0 = cyc;
    @(negedge ACLK); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      if (cmd_ready) busy_rdy++;
      @(negedge ACLK); #1;
    end
    lat = cyc - t0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge ACLK);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if ({M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY} !== 5'b0) begin
      errors++; $display("FAIL rst_valid_ready got %b exp 00000",
        {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_RREADY, M_AXI_BREADY}); end
    checks++; if ({rsp_valid, rsp_rdata, rsp_resp} !== 35'd0) begin
      errors++; $display("FAIL rst_rsp got %b/%h/%b exp 0/0/0", rsp_valid, rsp_rdata, rsp_resp); end
    checks++; if ({M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB} !== 68'd0) begin
      errors++; $display("FAIL rst_cmd_regs got %h/%h/%h exp 0", M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB); end
    ARESETN = 1'b1;
    @(negedge ACLK); #1;
  endtask

  task automatic test_fill();
    int lat, t0, br; logic ok;
    for (int i = 0; i < 16; i++) begin
      do_cmd(1'b1, 32'(i * 4), 32'd0, 4'hF, lat, t0, br, ok);
      ref_mem[i] = 32'd0;
      checks++; if (!ok || rsp_resp !== 2'b00) begin
        errors++; $display("FAIL fill_%0d ok %b resp %b exp 1/00", i, ok, rsp_resp); end
      @(negedge ACLK); #1;
    end
  endtask

  task automatic test_write_basic();
    int lat, t0, br; logic ok;
    do_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, lat, t0, br, ok);
    ref_mem[1] = apply_strb(ref_mem[1], 32'hDEADBEEF, 4'hF);
    checks++; if (!ok || lat != 3) begin errors++; $display("FAIL wr_latency got %0d ok %b exp 3", lat, ok); end
    checks++; if (aw_hs_cyc - t0 != 1 || w_hs_cyc - t0 != 1) begin
      errors++; $display("FAIL wr_hs_cycle got aw %0d w %0d exp 1 1", aw_hs_cyc - t0, w_hs_cyc - t0); end
    checks++; if (rsp_resp !== 2'b00 || rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL wr_rsp got %b/%h exp 00/0", rsp_resp, rsp_rdata); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_at_rsp got %b exp 1", cmd_ready); end
    @(negedge ACLK); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read_basic();
    int lat, t0, br; logic ok;
    do_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat, t0, br, ok);
    checks++; if (!ok || lat != 3) begin errors++; $display("FAIL rd_latency got %0d ok %b exp 3", lat, ok); end
    checks++; if (ar_addr_seen !== 32'h4) begin errors++; $display("FAIL rd_araddr got %h exp 4", ar_addr_seen); end
    checks++; if (rsp_rdata !== ref_mem[1] || rsp_resp !== 2'b00) begin
      errors++; $display("FAIL rd_data got %h/%b exp %h/00", rsp_rdata, rsp_resp, ref_mem[1]); end
    checks++; if (br != 0) begin errors++; $display("FAIL rd_busy_ready got %0d exp 0", br); end
    @(negedge ACLK); #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_hold got %b/%h exp 0/deadbeef", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_w_first();
    int lat, t0, br, awv0, wv0, b0, se0; logic ok;
    aw_delay = 3; w_delay = 0;
    awv0 = awv_cnt; wv0 = wv_cnt; b0 = b_hs_cnt; se0 = stab_err;
    do_cmd(1'b1, 32'h10, 32'h12345678, 4'h5, lat, t0, br, ok);
    ref_mem[4] = apply_strb(ref_mem[4], 32'h12345678, 4'h5);
    checks++; if (!ok || lat != 6) begin errors++; $display("FAIL wfirst_latency got %0d exp 6", lat); end
    checks++; if (w_hs_cyc - t0 != 1 || aw_hs_cyc - t0 != 4) begin
      errors++; $display("FAIL wfirst_hs got w %0d aw %0d exp 1 4", w_hs_cyc - t0, aw_hs_cyc - t0); end
    checks++; if (wv_cnt - wv0 != 1 || awv_cnt - awv0 != 4) begin
      errors++; $display("FAIL wfirst_valid_cycles got w %0d aw %0d exp 1 4", wv_cnt - wv0, awv_cnt - awv0); end
    checks++; if (b_hs_cnt - b0 != 1) begin errors++; $display("FAIL wfirst_b_count got %0d exp 1", b_hs_cnt - b0); end
    checks++; if (stab_err != se0) begin errors++; $display("FAIL wfirst_stable got %0d exp %0d", stab_err, se0); end
    aw_delay = 0;
    @(negedge ACLK); #1;
  endtask

  task automatic test_read_slverr();
    int lat, t0, br, a0, s0, r0; logic ok;
    ar_delay = 4; rresp_cfg = 2'b10;
    a0 = arv_cnt; s0 = ar_stall_cnt; r0 = rsp_cnt;
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, lat, t0, br, ok);
    checks++; if (!ok || lat != 7) begin errors++; $display("FAIL slverr_latency got %0d exp 7", lat); end
    checks++; if (arv_cnt - a0 != 5 || ar_stall_cnt - s0 != 4) begin
      errors++; $display("FAIL slverr_arvalid got %0d/%0d exp 5/4", arv_cnt - a0, ar_stall_cnt - s0); end
    checks++; if (rsp_resp !== 2'b10 || rsp_rdata !== ref_mem[4]) begin
      errors++; $display("FAIL slverr_rsp got %b/%h exp 10/%h", rsp_resp, rsp_rdata, ref_mem[4]); end
    @(negedge ACLK); #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_cnt - r0 != 1) begin
      errors++; $display("FAIL slverr_pulse got %b cnt %0d exp 0 1", rsp_valid, rsp_cnt - r0); end
    ar_delay = 0; rresp_cfg = 2'b00;
  endtask

  task automatic test_reset_in_wresp();
    int lat, t0, br, r0, n; logic ok;
    b_hold = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
    @(negedge ACLK); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!M_AXI_BREADY && n < 20) begin @(negedge ACLK); #1; n++; end
    checks++; if (!M_AXI_BREADY) begin errors++; $display("FAIL rstw_bready got %b exp 1", M_AXI_BREADY); end
    ref_mem[8] = 32'hCAFEF00D;
    r0 = rsp_cnt;
    ARESETN = 1'b0;
    #1;
    checks++; if (M_AXI_BREADY !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstw_async got bready %b rsp %b ready %b exp 0 0 1", M_AXI_BREADY, rsp_valid, cmd_ready); end
    repeat (2) @(negedge ACLK);
    #1; ARESETN = 1'b1; b_hold = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    checks++; if (rsp_cnt != r0) begin errors++; $display("FAIL rstw_no_rsp got %0d exp %0d", rsp_cnt, r0); end
    do_cmd(1'b0, 32'h20, 32'h0, 4'h0, lat, t0, br, ok);
    checks++; if (!ok || lat != 3 || rsp_rdata !== ref_mem[8] || rsp_resp !== 2'b00) begin
      errors++; $display("FAIL rstw_read got lat %0d data %h resp %b exp 3 %h 00", lat, rsp_rdata, rsp_resp, ref_mem[8]); end
    @(negedge ACLK); #1;
  endtask

  task automatic test_back_to_back();
    int lat, t0, br; logic ok;
    logic [31:0] da, db;
    da = $urandom; db = $urandom;
    do_cmd(1'b1, 32'h30, da, 4'hF, lat, t0, br, ok);
    ref_mem[12] = da;
    do_cmd(1'b1, 32'h34, db, 4'hF, lat, t0, br, ok);
    ref_mem[13] = db;
    checks++; if (!ok || lat != 3) begin errors++; $display("FAIL b2b_wr_latency got %0d exp 3", lat); end
    do_cmd(1'b0, 32'h30, 32'h0, 4'h0, lat, t0, br, ok);
    checks++; if (!ok || lat != 3 || rsp_rdata !== ref_mem[12]) begin
      errors++; $display("FAIL b2b_rd0 got lat %0d data %h exp 3 %h", lat, rsp_rdata, ref_mem[12]); end
    do_cmd(1'b0, 32'h34, 32'h0, 4'h0, lat, t0, br, ok);
    checks++; if (!ok || lat != 3 || rsp_rdata !== ref_mem[13]) begin
      errors++; $display("FAIL b2b_rd1 got lat %0d data %h exp 3 %h", lat, rsp_rdata, ref_mem[13]); end
    @(negedge ACLK); #1;
  endtask

  task automatic test_random();
    int lat, t0, br, ad, wd, rd, exp_lat, se0;
    logic ok, wr;
    logic [3:0] idx, s;
    logic [31:0] d, exp_rd;
    logic [1:0] rr;
    se0 = stab_err;
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom % 2); idx = 4'($urandom); s = 4'($urandom); d = $urandom;
      ad = int'($urandom % 4); wd = int'($urandom % 4); rd = int'($urandom % 4); rr = 2'($urandom);
      aw_delay = ad; w_delay = wd; ar_delay = rd; rresp_cfg = rr; bresp_cfg = rr;
      do_cmd(wr, {26'd0, idx, 2'b00}, d, s, lat, t0, br, ok);
      if (wr) begin
        ref_mem[idx] = apply_strb(ref_mem[idx], d, s);
        exp_lat = 3 + ((ad > wd) ? ad : wd);
        exp_rd = 32'd0;
      end else begin
        exp_lat = 3 + rd;
        exp_rd = ref_mem[idx];
      end
      checks++; if (!ok || lat != exp_lat || br != 0) begin
        errors++; $display("FAIL rnd%0d_timing wr %b got lat %0d busy_rdy %0d exp %0d 0", n, wr, lat, br, exp_lat); end
      checks++; if (rsp_rdata !== exp_rd || rsp_resp !== rr) begin
        errors++; $display("FAIL rnd%0d_rsp wr %b got %h/%b exp %h/%b", n, wr, rsp_rdata, rsp_resp, exp_rd, rr); end
      @(negedge ACLK); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_pulse got %b exp 0", n, rsp_valid); end
    end
    checks++; if (stab_err != se0) begin errors++; $display("FAIL rnd_stable got %0d exp %0d", stab_err, se0); end
    aw_delay = 0; w_delay = 0; ar_delay = 0; rresp_cfg = 2'b00; bresp_cfg = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_write_basic();
    test_read_basic();
    test_w_first();
    test_read_slverr();
    test_reset_in_wresp();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_axi4_lite_master
`default_nettype wire
